// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if
//   Bundles the CPU memory ports and the program-loader port of the
//   memory responder. The master modport is the CPU/host side, the slave
//   modport is the responder.
//
//   CPU side:    read_mem_ir/mem_radrs_ir -> instruction_fetch
//                read_mem_str/mem_radrs_ld -> mem_store_data
//                write_mem/mem_wadrs/mem_wdata
//   Loader side: load_start, load_valid/load_data/load_last -> load_ready
//                status load_busy, load_err, load_count, cpu_resetn
interface cpu_mem_responder_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic          read_mem_ir;
  logic [AW-1:0] mem_radrs_ir;
  logic [DW-1:0] instruction_fetch;
  logic          read_mem_str;
  logic [AW-1:0] mem_radrs_ld;
  logic [DW-1:0] mem_store_data;
  logic          write_mem;
  logic [AW-1:0] mem_wadrs;
  logic [DW-1:0] mem_wdata;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_busy;
  logic          load_err;
  logic [AW:0]   load_count;
  logic          cpu_resetn;

  modport master (
    output read_mem_ir, mem_radrs_ir, read_mem_str, mem_radrs_ld,
           write_mem, mem_wadrs, mem_wdata,
           load_start, load_valid, load_data, load_last,
    input  instruction_fetch, mem_store_data,
           load_ready, load_busy, load_err, load_count, cpu_resetn
  );

  modport slave (
    input  read_mem_ir, mem_radrs_ir, read_mem_str, mem_radrs_ld,
           write_mem, mem_wadrs, mem_wdata,
           load_start, load_valid, load_data, load_last,
    output instruction_fetch, mem_store_data,
           load_ready, load_busy, load_err, load_count, cpu_resetn
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Unified word-addressed RAM serving the CPU instruction-fetch read port,
//   load-data read port and store write port, plus a program loader that
//   fills RAM from address 0 while holding the CPU in reset.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset (RAM contents are kept)
//   bus      cpu_mem_responder_if.slave, CPU and loader signals
//   state_o  FSM state for debug (0 IDLE, 1 LOAD, 2 RUN)
//
// Loader handshake: a beat transfers on a rising edge where load_valid and
// load_ready are both 1. load_ready is a registered output that is 1 exactly
// while the FSM is in LOAD; load_valid is ignored at all other times and
// load_last is only meaningful on a transferring beat.
module cpu_mem_responder #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  cpu_mem_responder_if.slave bus,
  output logic [1:0]         state_o
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e        state_q;
  logic          load_ready_q;
  logic          load_busy_q;
  logic          load_err_q;
  logic [AW:0]   load_count_q;
  logic          cpu_resetn_q;
  logic [DW-1:0] fetch_q;
  logic [DW-1:0] ld_data_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          beat_fire_d;
  logic [AW:0]   count_inc_d;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;
  logic [DW-1:0] rd_ir_d;
  logic [DW-1:0] rd_ld_d;

  assign beat_fire_d = (state_q == ST_LOAD) && load_ready_q && bus.load_valid;
  // Saturate at DEPTH so an overrun never wraps the count back to 0.
  assign count_inc_d = (load_count_q == DEPTH_W) ? load_count_q : load_count_q + 1'b1;

  // Single RAM write port: loader beats in LOAD, CPU stores only in RUN.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = bus.mem_wadrs;
    wr_data_d = bus.mem_wdata;
    if (beat_fire_d) begin
      wr_en_d   = (load_count_q < DEPTH_W);
      wr_addr_d = load_count_q[AW-1:0];
      wr_data_d = bus.load_data;
    end else if ((state_q == ST_RUN) && bus.write_mem) begin
      wr_en_d = ({1'b0, bus.mem_wadrs} < DEPTH_W);
    end
  end

  // Write-first read muxes; unmapped addresses read as 0.
  always_comb begin
    rd_ir_d = '0;
    if ({1'b0, bus.mem_radrs_ir} < DEPTH_W) begin
      if (wr_en_d && (wr_addr_d == bus.mem_radrs_ir)) rd_ir_d = wr_data_d;
      else                                            rd_ir_d = mem_q[bus.mem_radrs_ir[IW-1:0]];
    end
  end

  always_comb begin
    rd_ld_d = '0;
    if ({1'b0, bus.mem_radrs_ld} < DEPTH_W) begin
      if (wr_en_d && (wr_addr_d == bus.mem_radrs_ld)) rd_ld_d = wr_data_d;
      else                                            rd_ld_d = mem_q[bus.mem_radrs_ld[IW-1:0]];
    end
  end

  // RAM array has no reset so program contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_addr_d[IW-1:0]] <= wr_data_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q   <= '0;
      ld_data_q <= '0;
    end else begin
      if (bus.read_mem_ir)  fetch_q   <= rd_ir_d;
      if (bus.read_mem_str) ld_data_q <= rd_ld_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_err_q   <= 1'b0;
      load_count_q <= '0;
      cpu_resetn_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          // Reprogramming from RUN re-resets the CPU from the next edge.
          if (bus.load_start) begin
            state_q      <= ST_LOAD;
            load_ready_q <= 1'b1;
            load_busy_q  <= 1'b1;
            load_err_q   <= 1'b0;
            load_count_q <= '0;
            cpu_resetn_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (beat_fire_d) begin
            load_count_q <= count_inc_d;
            if (bus.load_last || (load_count_q == LAST_W)) begin
              state_q      <= ST_RUN;
              load_ready_q <= 1'b0;
              load_busy_q  <= 1'b0;
              cpu_resetn_q <= 1'b1;
              // Filling the last word without load_last is an overrun.
              if (!bus.load_last) load_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b0;
          load_busy_q  <= 1'b0;
          cpu_resetn_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction_fetch = fetch_q;
  assign bus.mem_store_data    = ld_data_q;
  assign bus.load_ready        = load_ready_q;
  assign bus.load_busy         = load_busy_q;
  assign bus.load_err          = load_err_q;
  assign bus.load_count        = load_count_q;
  assign bus.cpu_resetn        = cpu_resetn_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
//   Directed bench for cpu_mem_responder: one instance at the default depth
//   and one at DEPTH=16 for the overrun and unmapped-address cases.
module tb_cpu_mem_responder;
  localparam int AW = 11;
  localparam int DW = 32;

  logic       clk;
  logic       reset;
  logic [1:0] state;
  logic [1:0] state16;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [31:0] prog [4];
  logic [31:0] gap_v [4];
  logic [31:0] rst_v [3];

  cpu_mem_responder_if #(.AW(AW), .DW(DW)) bus ();
  cpu_mem_responder_if #(.AW(AW), .DW(DW)) bus16 ();

  cpu_mem_responder #(.DEPTH(2048), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(state)
  );

  cpu_mem_responder #(.DEPTH(16), .AW(AW), .DW(DW)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .state_o(state16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.read_mem_ir  = 1'b0; bus.mem_radrs_ir = '0;
    bus.read_mem_str = 1'b0; bus.mem_radrs_ld = '0;
    bus.write_mem    = 1'b0; bus.mem_wadrs    = '0; bus.mem_wdata = '0;
    bus.load_start   = 1'b0; bus.load_valid   = 1'b0;
    bus.load_data    = '0;   bus.load_last    = 1'b0;
  endtask

  task automatic clear_bus16();
    bus16.read_mem_ir  = 1'b0; bus16.mem_radrs_ir = '0;
    bus16.read_mem_str = 1'b0; bus16.mem_radrs_ld = '0;
    bus16.write_mem    = 1'b0; bus16.mem_wadrs    = '0; bus16.mem_wdata = '0;
    bus16.load_start   = 1'b0; bus16.load_valid   = 1'b0;
    bus16.load_data    = '0;   bus16.load_last    = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    prog  = '{32'hE000_0005, 32'h8001_0001, 32'h0000_0000, 32'hA000_0000};
    gap_v = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0BAD_0004};
    rst_v = '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002};
    clear_bus();
    clear_bus16();
    reset = 1'b1;

    // Reset values
    #3;
    check("rst_fetch",  bus.instruction_fetch, 32'h0);
    check("rst_store",  bus.mem_store_data,    32'h0);
    check("rst_ready",  32'(bus.load_ready),   32'h0);
    check("rst_busy",   32'(bus.load_busy),    32'h0);
    check("rst_err",    32'(bus.load_err),     32'h0);
    check("rst_count",  32'(bus.load_count),   32'h0);
    check("rst_cpurn",  32'(bus.cpu_resetn),   32'h0);
    check("rst_state",  32'(state),            32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle stays idle without load_start, loader beats ignored
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    check("idle_state", 32'(state),          32'h0);
    check("idle_ready", 32'(bus.load_ready), 32'h0);
    check("idle_count", 32'(bus.load_count), 32'h0);

    // Four-beat program load
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("ld_state",  32'(state),          32'h1);
    check("ld_ready",  32'(bus.load_ready), 32'h1);
    check("ld_busy",   32'(bus.load_busy),  32'h1);
    check("ld_cpurn",  32'(bus.cpu_resetn), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_last  = (i == 3);
      tick();
      if (i == 2) check("ld_cpurn_pre", 32'(bus.cpu_resetn), 32'h0);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    check("ld_cpurn_post", 32'(bus.cpu_resetn), 32'h1);
    check("ld_count",      32'(bus.load_count), 32'd4);
    check("ld_err",        32'(bus.load_err),   32'h0);
    check("ld_state_run",  32'(state),          32'h2);
    check("ld_ready_run",  32'(bus.load_ready), 32'h0);
    check("ld_busy_run",   32'(bus.load_busy),  32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.read_mem_ir  = 1'b1;
      bus.mem_radrs_ir = AW'(i);
      tick();
      check($sformatf("ld_rb%0d", i), bus.instruction_fetch, prog[i]);
    end
    bus.read_mem_ir  = 1'b0;
    bus.mem_radrs_ir = 11'h000;
    tick();
    check("ir_hold", bus.instruction_fetch, prog[3]);

    // CPU store then load-data readback and hold
    bus.write_mem = 1'b1; bus.mem_wadrs = 11'h030; bus.mem_wdata = 32'hAAAA_5555;
    tick();
    bus.mem_wadrs = 11'h010; bus.mem_wdata = 32'hDEAD_BEEF;
    tick();
    bus.write_mem    = 1'b0;
    bus.read_mem_str = 1'b1;
    bus.mem_radrs_ld = 11'h010;
    tick();
    check("st_rd", bus.mem_store_data, 32'hDEAD_BEEF);
    bus.read_mem_str = 1'b0;
    bus.mem_radrs_ld = 11'h000;
    tick();
    tick();
    check("st_hold", bus.mem_store_data, 32'hDEAD_BEEF);

    // Same-edge write and dual read: write-first
    bus.write_mem    = 1'b1; bus.mem_wadrs = 11'h020; bus.mem_wdata = 32'h1234_5678;
    bus.read_mem_ir  = 1'b1; bus.mem_radrs_ir = 11'h020;
    bus.read_mem_str = 1'b1; bus.mem_radrs_ld = 11'h020;
    tick();
    clear_bus();
    check("wf_ir", bus.instruction_fetch, 32'h1234_5678);
    check("wf_ld", bus.mem_store_data,    32'h1234_5678);

    // DEPTH=16 overrun: 17 beats, no load_last
    bus16.load_start = 1'b1;
    tick();
    bus16.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus16.load_valid = 1'b1;
      bus16.load_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    bus16.load_valid = 1'b0;
    check("ov_err",   32'(bus16.load_err),   32'h1);
    check("ov_count", 32'(bus16.load_count), 32'd16);
    check("ov_state", 32'(state16),          32'h2);
    check("ov_cpurn", 32'(bus16.cpu_resetn), 32'h1);
    bus16.read_mem_str = 1'b1; bus16.mem_radrs_ld = 11'd15;
    tick();
    check("ov_rd15", bus16.mem_store_data, 32'hC000_000F);
    bus16.write_mem   = 1'b1; bus16.mem_wadrs = 11'd20; bus16.mem_wdata = 32'hFFFF_FFFF;
    bus16.read_mem_ir = 1'b1; bus16.mem_radrs_ir = 11'd20;
    bus16.mem_radrs_ld = 11'd20;
    tick();
    check("ov_unmap_ir", bus16.instruction_fetch, 32'h0);
    check("ov_unmap_ld", bus16.mem_store_data,    32'h0);
    bus16.write_mem    = 1'b0;
    bus16.mem_radrs_ld = 11'd4;
    tick();
    check("ov_alias4", bus16.mem_store_data, 32'hC000_0004);
    clear_bus16();

    // Reload from RUN with gapped beats
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("gp_state", 32'(state),          32'h1);
    check("gp_cpurn", 32'(bus.cpu_resetn), 32'h0);
    check("gp_count", 32'(bus.load_count), 32'h0);
    bus.load_valid = 1'b1; bus.load_data = gap_v[0];
    tick();
    bus.load_valid = 1'b0;
    check("gp_count1", 32'(bus.load_count), 32'd1);
    tick();
    bus.load_valid = 1'b1; bus.load_data = gap_v[1];
    tick();
    bus.load_valid = 1'b0;
    bus.load_start = 1'b1;
    bus.write_mem  = 1'b1; bus.mem_wadrs = 11'h030; bus.mem_wdata = 32'h0;
    tick();
    bus.load_start = 1'b0;
    bus.write_mem  = 1'b0;
    check("gp_count2", 32'(bus.load_count), 32'd2);
    check("gp_still",  32'(state),          32'h1);
    tick();
    tick();
    bus.load_valid = 1'b1; bus.load_data = gap_v[2];
    tick();
    bus.load_valid = 1'b0;
    tick();
    tick();
    bus.load_valid = 1'b1; bus.load_data = gap_v[3]; bus.load_last = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    check("gp_count4", 32'(bus.load_count), 32'd4);
    check("gp_run",    32'(state),          32'h2);
    for (int i = 0; i < 4; i++) begin
      bus.read_mem_str = 1'b1;
      bus.mem_radrs_ld = AW'(i);
      tick();
      check($sformatf("gp_rb%0d", i), bus.mem_store_data, gap_v[i]);
    end
    bus.mem_radrs_ld = 11'h030;
    tick();
    check("gp_nowr", bus.mem_store_data, 32'hAAAA_5555);
    clear_bus();

    // Reset asserted mid-load
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = rst_v[i];
      tick();
    end
    bus.load_data = rst_v[2];
    #2;
    reset = 1'b1;
    #1;
    check("mr_state", 32'(state),            32'h0);
    check("mr_ready", 32'(bus.load_ready),   32'h0);
    check("mr_busy",  32'(bus.load_busy),    32'h0);
    check("mr_count", 32'(bus.load_count),   32'h0);
    check("mr_cpurn", 32'(bus.cpu_resetn),   32'h0);
    check("mr_fetch", bus.instruction_fetch, 32'h0);
    check("mr_store", bus.mem_store_data,    32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.read_mem_ir  = 1'b1;
      bus.mem_radrs_ir = AW'(i);
      tick();
      check($sformatf("mr_rb%0d", i), bus.instruction_fetch, (i < 2) ? rst_v[i] : gap_v[2]);
    end
    check("mr_idle", 32'(state), 32'h0);
    clear_bus();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the pipelined CPU's memory interface.
- Serves the CPU's instruction-fetch read port, load-data read port and store write port from one unified word-addressed RAM.
- Includes a program-loader port with a valid/ready handshake. The loader fills RAM from address 0 while holding the CPU in reset through cpu_resetn.
- Sits between the CPU and the testbench/host, at top level next to the cpu instance.

Parameters:
- DEPTH, 2048, number of 32-bit words implemented; addresses >= DEPTH are unmapped.
- AW, 11, address width of all CPU address ports.
- DW, 32, data word width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- read_mem_ir  in  1  instruction read enable
- mem_radrs_ir  in  AW  instruction read address
- instruction_fetch  out  DW  registered instruction read data
- read_mem_str  in  1  load-data read enable
- mem_radrs_ld  in  AW  load-data read address
- mem_store_data  out  DW  registered load-data read data
- write_mem  in  1  CPU write enable
- mem_wadrs  in  AW  CPU write address
- mem_wdata  in  DW  CPU write data
- load_start  in  1  one-cycle pulse that begins a program load
- load_valid  in  1  loader beat valid
- load_data  in  DW  loader beat data
- load_last  in  1  final beat marker, qualified by load_valid
- load_ready  out  1  loader can accept a beat
- load_busy  out  1  a load is in progress
- load_err  out  1  sticky: the load overran DEPTH
- load_count  out  AW+1  number of beats written by the current/last load
- cpu_resetn  out  1  active-low reset to the CPU

Behaviour:
- Reset (asynchronous, active-high): instruction_fetch=0, mem_store_data=0, load_ready=0, load_busy=0, load_err=0, load_count=0, cpu_resetn=0, FSM=IDLE. RAM contents are not cleared.
- Read ports are independent, each with 1-cycle latency:
  - read_mem_ir=1 at edge N: instruction_fetch shows RAM[mem_radrs_ir] after edge N.
  - read_mem_ir=0: instruction_fetch holds its value.
  - mem_store_data/read_mem_str/mem_radrs_ld behave identically.
  - Reading an unmapped address (>= DEPTH) returns 0.
- CPU write: write_mem=1 at edge N writes mem_wdata to RAM[mem_wadrs].
  - Ignored if the address is unmapped or the FSM is not RUN.
- Read-during-write to the same address on the same edge: write-first. The read port returns mem_wdata (or load_data for a loader write). This applies to both read ports simultaneously.
- FSM states are IDLE, LOAD, RUN.
  - IDLE: cpu_resetn=0, load_ready=0. The FSM leaves IDLE only on load_start=1 and goes to LOAD.
  - On entry to LOAD, load_count clears to 0 and load_err clears to 0.
  - LOAD: load_ready=1, load_busy=1, cpu_resetn=0.
    - Each beat with load_valid & load_ready writes load_data to RAM[load_count] and increments load_count.
    - load_last on an accepted beat goes to RUN on the next edge.
  - Overrun: a beat accepted when load_count=DEPTH-1 without load_last sets load_err=1 and goes to RUN. That beat is still written.
  - RUN: cpu_resetn=1 starting the cycle after the last beat is accepted; load_ready=0, load_busy=0. CPU writes are honoured.
    - load_start in RUN goes back to LOAD with cpu_resetn=0 from the next edge, so reprogramming re-resets the CPU.
- load_start while in LOAD is ignored.
- load_valid outside LOAD is ignored; load_ready is 0.
- CPU read ports are serviced in all states.
- Reset asserted mid-load: everything returns to IDLE immediately. Beats already written stay in RAM.
- Widths:
  - Addresses are compared unsigned against DEPTH.
  - load_count saturates at DEPTH; it never wraps to 0.

Test Plan:
- Reset, then load_start, then 4 beats 0xE0000005, 0x80010001, 0x00000000, 0xA0000000 with load_last on beat 4 -> load_count=4, load_err=0, cpu_resetn rises exactly one cycle after beat 4 is accepted, readback of addresses 0..3 matches.
- In RUN, write_mem=1, mem_wadrs=0x010, mem_wdata=0xDEADBEEF; the next edge has read_mem_str=1, mem_radrs_ld=0x010 -> mem_store_data=0xDEADBEEF one cycle later and holds while read_mem_str=0.
- Same-edge write 0x12345678 to 0x020 with both reads at 0x020 -> instruction_fetch=mem_store_data=0x12345678 after that edge (write-first).
- DEPTH=16: stream 17 beats without load_last -> beat 16 written to address 15, load_err=1, load_count=16, FSM=RUN; a read of address 20 returns 0 and a write to 20 is dropped.
- Assert reset after 2 of 5 loader beats -> outputs return to reset values asynchronously, cpu_resetn=0, FSM=IDLE; addresses 0..1 keep their data.
- load_valid pulses with gaps of 1-3 idle cycles during LOAD -> only handshaked beats are written and counted; load_start during LOAD does not clear load_count.
